// File: rtl/muldiv_unit.sv
// muldiv_unit -- multi-cycle multiply/divide unit for the EX stage.
//
// Executes MULT/MULTU/DIV/DIVU behind a single start/annul/ready handshake
// and returns a {hi,lo} pair for the datapath to write into hilo_reg.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   start_i         request; op/operands captured on the accepting edge
//   op_i[1:0]       00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   opa_i, opb_i    multiplicand/dividend, multiplier/divisor
//   annul_i         abort the operation in flight; also blocks a start
//   busy_o          high while in MUL or DIV (feeds the F/D/E stall)
//   ready_o         one-cycle pulse, hi_o/lo_o carry a new result
//   hi_o, lo_o      MUL: product high/low half; DIV: remainder/quotient
//   div_by_zero_o   qualifies the last result: divide with opb == 0
module muldiv_unit #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] opa_i,
  input  logic [WIDTH-1:0] opb_i,
  input  logic             annul_i,
  output logic             busy_o,
  output logic             ready_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             div_by_zero_o
);

  // Counter must also hold MUL_LAT should it ever exceed WIDTH.
  localparam int CNT_MAX = (WIDTH > MUL_LAT) ? WIDTH : MUL_LAT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d;       // raw opa: multiplicand, or hi on divide-by-zero
  logic [WIDTH-1:0]   b_q, b_d;       // raw opb for MUL, |divisor| for DIV
  logic [WIDTH-1:0]   quo_q, quo_d;   // |dividend| shifting out, quotient shifting in
  logic [WIDTH:0]     rem_q, rem_d;   // partial remainder, one extra bit for the shift
  logic               sgn_q, sgn_d;   // signed multiply
  logic               negq_q, negq_d; // negate quotient at the end
  logic               negr_q, negr_d; // negate remainder at the end
  logic               zero_q, zero_d; // divisor was zero
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               dz_q, dz_d;

  // Start accepted from IDLE or DONE; annul in those states kills it.
  logic accept;
  assign accept = start_i && !annul_i && (state_q == S_IDLE || state_q == S_DONE);

  logic is_signed, a_neg, b_neg;
  assign is_signed = ~op_i[0];
  assign a_neg     = is_signed & opa_i[WIDTH-1];
  assign b_neg     = is_signed & opb_i[WIDTH-1];

  // Product of the latched operands. Sign-extending to 2W and keeping the
  // low 2W bits of the product gives the two's-complement result directly.
  logic [2*WIDTH-1:0] ext_a, ext_b, prod;
  assign ext_a = {{WIDTH{sgn_q & a_q[WIDTH-1]}}, a_q};
  assign ext_b = {{WIDTH{sgn_q & b_q[WIDTH-1]}}, b_q};
  assign prod  = ext_a * ext_b;

  // One restoring-division step: shift in the next dividend bit, subtract
  // the divisor when it fits. The remainder after a step is < divisor.
  logic [WIDTH:0]   shifted, rem_n;
  logic [WIDTH-1:0] quo_n, rem_lo;
  logic             fits;
  assign shifted = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
  assign fits    = shifted >= {1'b0, b_q};
  assign rem_n   = fits ? (shifted - {1'b0, b_q}) : shifted;
  assign quo_n   = {quo_q[WIDTH-2:0], fits};
  assign rem_lo  = rem_n[WIDTH-1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    sgn_d   = sgn_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    zero_d  = zero_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dz_d    = dz_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          a_d   = opa_i;
          sgn_d = is_signed;
          if (op_i[1]) begin
            state_d = S_DIV;
            b_d     = b_neg ? -opb_i : opb_i;
            quo_d   = a_neg ? -opa_i : opa_i;
            rem_d   = '0;
            negq_d  = a_neg ^ b_neg;
            negr_d  = a_neg;
            zero_d  = (opb_i == '0);
            cnt_d   = (opb_i == '0) ? CNT_ONE : CNT_W'(WIDTH);
          end else begin
            state_d = S_MUL;
            b_d     = opb_i;
            cnt_d   = CNT_W'(MUL_LAT);
          end
        end else if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
      end
      S_MUL: begin
        if (annul_i) begin
          state_d = S_IDLE;
        end else if (cnt_q == CNT_ONE) begin
          state_d = S_DONE;
          hi_d    = prod[2*WIDTH-1:WIDTH];
          lo_d    = prod[WIDTH-1:0];
          dz_d    = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_DIV: begin
        if (annul_i) begin
          state_d = S_IDLE;
        end else if (zero_q) begin
          state_d = S_DONE;
          lo_d    = '1;
          hi_d    = a_q;
          dz_d    = 1'b1;
        end else begin
          rem_d = rem_n;
          quo_d = quo_n;
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            // MIN / -1 needs no special case: |MIN| fits unsigned and the
            // quotient is not negated, so it wraps to MIN with remainder 0.
            state_d = S_DONE;
            lo_d    = negq_q ? -quo_n : quo_n;
            hi_d    = negr_q ? -rem_lo : rem_lo;
            dz_d    = 1'b0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      sgn_q   <= 1'b0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      zero_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      sgn_q   <= sgn_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      zero_q  <= zero_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dz_q    <= dz_d;
    end
  end

  assign busy_o        = (state_q == S_MUL) || (state_q == S_DIV);
  assign ready_o       = (state_q == S_DONE);
  assign hi_o          = hi_q;
  assign lo_o          = lo_q;
  assign div_by_zero_o = dz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit (WIDTH=32, MUL_LAT=2).
module tb_muldiv_unit;
  localparam int W  = 32;
  localparam int ML = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_i, annul_i;
  logic [1:0]    op_i;
  logic [W-1:0]  opa_i, opb_i;
  logic          busy_o, ready_o, div_by_zero_o;
  logic [W-1:0]  hi_o, lo_o;

  muldiv_unit #(.WIDTH(W), .MUL_LAT(ML)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i),
    .opa_i(opa_i), .opb_i(opb_i), .annul_i(annul_i),
    .busy_o(busy_o), .ready_o(ready_o), .hi_o(hi_o), .lo_o(lo_o),
    .div_by_zero_o(div_by_zero_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;   // index of the last rising edge
  int nready = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int           at;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference arithmetic in 64-bit integers.
  function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t        e;
    longint      sa, sb2, q, r;
    logic [63:0] p, qv, rv;
    sa  = longint'($signed(a));
    sb2 = longint'($signed(b));
    e.dz = 1'b0;
    e.at = 0;
    case (op)
      2'b00: begin p = sa * sb2; e.hi = p[63:32]; e.lo = p[31:0]; end
      2'b01: begin p = {32'b0, a} * {32'b0, b}; e.hi = p[63:32]; e.lo = p[31:0]; end
      default: begin
        if (b == 0) begin
          e.lo = '1; e.hi = a; e.dz = 1'b1;
        end else if (op == 2'b11) begin
          e.lo = a / b; e.hi = a % b;
        end else begin
          q = sa / sb2; r = sa % sb2;
          qv = q; rv = r;
          e.lo = qv[31:0]; e.hi = rv[31:0];
        end
      end
    endcase
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst && ready_o) begin
      nready++;
      if (sb.size() == 0) chk("spurious_ready", 1, 0);
      else begin
        mon_e = sb.pop_front();
        chk("hi", hi_o, mon_e.hi);
        chk("lo", lo_o, mon_e.lo);
        chk("dz", div_by_zero_o, mon_e.dz);
        chk("ready_cycle", cyc, mon_e.at);
        chk("busy_in_done", busy_o, 0);
      end
    end
  end

  // Called at a negedge while the unit can accept; returns one negedge later.
  task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int   n;
    n = op[1] ? ((b == 0) ? 1 : W) : ML;
    start_i = 1'b1; op_i = op; opa_i = a; opb_i = b;
    e = model(op, a, b);
    e.at = cyc + 1 + n;
    sb.push_back(e);
    @(negedge clk);
    start_i = 1'b0;
    opa_i = $urandom; opb_i = $urandom; op_i = 2'($urandom_range(0, 3));
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!ready_o && n < 100) begin @(negedge clk); n++; end
    if (!ready_o) chk("ready_timeout", 0, 1);
  endtask

  function automatic logic [W-1:0] rnd_val();
    case ($urandom_range(0, 6))
      0: return '0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return W'($urandom_range(0, 20));
      4: return -W'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  logic [W-1:0] old_hi, old_lo;
  int           k, nr0;

  initial begin
    rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; op_i = '0; opa_i = '0; opb_i = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy_o, 0);
    chk("rst_ready", ready_o, 0);
    chk("rst_hi", hi_o, 0);
    chk("rst_lo", lo_o, 0);
    chk("rst_dz", div_by_zero_o, 0);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases, issued back-to-back in each DONE cycle.
    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF); wait_ready();
    issue(2'b00, -32'd3, 32'd5);                wait_ready();
    issue(2'b10, -32'd7, 32'd2);                wait_ready();
    issue(2'b11, 32'd7, 32'd2);                 wait_ready();
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF); wait_ready();
    issue(2'b11, 32'd9, 32'd0);                 wait_ready();
    @(negedge clk);

    // start while busy must be ignored
    issue(2'b01, 32'd6, 32'd7);
    chk("busy_mul", busy_o, 1);
    start_i = 1'b1; op_i = 2'b11; opa_i = 32'd100; opb_i = 32'd0;
    @(negedge clk);
    start_i = 1'b0;
    wait_ready();
    @(negedge clk);

    // annul in cycle k+10 of a DIV
    old_hi = hi_o; old_lo = lo_o; nr0 = nready;
    issue(2'b10, 32'd1000, 32'd3);
    k = cyc;
    repeat (9) @(negedge clk);
    annul_i = 1'b1;
    void'(sb.pop_back());
    @(negedge clk);
    annul_i = 1'b0;
    chk("annul_busy", busy_o, 0);
    repeat (40) @(negedge clk);
    chk("annul_hi", hi_o, old_hi);
    chk("annul_lo", lo_o, old_lo);
    chk("annul_no_ready", nready, nr0);
    chk("annul_dz", div_by_zero_o, 0);

    // annul in IDLE blocks the start
    start_i = 1'b1; annul_i = 1'b1; op_i = 2'b01; opa_i = 32'd3; opb_i = 32'd3;
    @(negedge clk);
    start_i = 1'b0; annul_i = 1'b0;
    chk("annul_blocks_start", busy_o, 0);

    // reset in the middle of a DIV
    issue(2'b10, 32'd12345, 32'd67);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    void'(sb.pop_back());
    chk("midrst_busy", busy_o, 0);
    chk("midrst_ready", ready_o, 0);
    chk("midrst_hi", hi_o, 0);
    chk("midrst_lo", lo_o, 0);
    chk("midrst_dz", div_by_zero_o, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("post_rst_busy", busy_o, 0);

    // random back-to-back traffic
    for (int i = 0; i < 1000; i++) begin
      logic [1:0]   op;
      logic [W-1:0] a, b;
      op = 2'($urandom_range(0, 3));
      a  = rnd_val();
      b  = rnd_val();
      issue(op, a, b);
      wait_ready();
    end
    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
